// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment types, blank pattern and hex-to-segment decode
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low pattern, bit 6 = segment a down to bit 0 = segment g
    function automatic seg7_t nibble_to_seg(input logic [3:0] nib);
        seg7_t seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// rtl/seg7_lut.sv - combinational nibble to active-low seven-segment pattern
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    assign o_seg = nibble_to_seg(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit common-anode display driver
// Scans one digit per slot with a blanked guard interval; new values land only at frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GUARD_CYCLES  = 500,
    parameter int BLANK_LEADING = 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    output seg7_t                   seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    pending
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_GUARD = PW'(GUARD_CYCLES);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_prescaler;
    logic [DW-1:0]           r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;
    seg7_t                   r_seg_n;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an_n;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_active;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    seg7_t                   w_lut_seg;

    assign w_slot_end  = enable && (r_prescaler == PRE_LAST);
    assign w_frame_end = w_slot_end && (r_digit_idx == DIG_LAST);
    assign w_active    = enable && (r_prescaler >= PRE_GUARD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler <= '0;
            r_digit_idx <= '0;
        end else if (enable) begin
            if (r_prescaler == PRE_LAST) begin
                r_prescaler <= '0;
                r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
        end
    end

    // A load coinciding with the boundary bypasses the pending stage entirely
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_frame_end) begin
            r_pend_valid <= 1'b0;
            if (load) begin
                r_disp_val <= value;
                r_disp_dp  <= dp_en;
            end else if (r_pend_valid) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
        end else if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp_en;
            r_pend_valid <= 1'b1;
        end
    end

    always_comb begin
        logic v_zero_run;
        w_nibble   = 4'h0;
        w_dp       = 1'b0;
        w_blank    = 1'b0;
        w_an_sel   = '1;
        v_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_zero_run = v_zero_run && (r_disp_val[4*k +: 4] == 4'h0);
            if (r_digit_idx == DW'(k)) begin
                w_nibble    = r_disp_val[4*k +: 4];
                w_dp        = r_disp_dp[k];
                w_an_sel[k] = 1'b0;
                w_blank     = (BLANK_LEADING != 0) && (k != 0) && v_zero_run;
            end
        end
    end

    seg7_lut u_lut (
        .i_nibble (w_nibble),
        .o_seg    (w_lut_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
        end else if (w_active) begin
            r_seg_n <= w_blank ? SEG_BLANK : w_lut_seg;
            r_dp_n  <= ~w_dp;
            r_an_n  <= w_an_sel;
        end else begin
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
        end
    end

    assign seg_n   = r_seg_n;
    assign dp_n    = r_dp_n;
    assign an_n    = r_an_n;
    assign pending = r_pend_valid;

endmodule
